// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine
//   SPI master serial-clock engine. Divides PCLK by (sppr+1)*2^(spr+1) to
//   produce SCLK, frames a transfer of N bits and issues one-cycle
//   load/shift/sample/last/done strobes for the data shifter. Drives the
//   active-low slave select.
//   Optional feature macro: SPI_SCLK_HOLD_EN adds hold_i, which freezes
//   the frame timing (counters and SCLK) while high.
module spi_sclk_engine #(
  parameter int SPPR_W   = 3,
  parameter int SPR_W    = 3,
  parameter int DIV_W    = 12,
  parameter int MAX_BITS = 32,
  parameter int BITS_W   = 6
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              en_i,
  input  logic [1:0]        spi_mode_i,
  input  logic              spiswai_i,
  input  logic              cpol_i,
  input  logic              cphase_i,
  input  logic [SPPR_W-1:0] sppr_i,
  input  logic [SPR_W-1:0]  spr_i,
  input  logic [BITS_W-1:0] nbits_i,
  input  logic              start_i,
`ifdef SPI_SCLK_HOLD_EN
  input  logic              hold_i,
`endif
  output logic              sclk_o,
  output logic              ss_n_o,
  output logic              busy_o,
  output logic              load_o,
  output logic              shift_o,
  output logic              sample_o,
  output logic              last_o,
  output logic              done_o,
  output logic [DIV_W-1:0]  BaudRateDivisor_o
);

  localparam int EDGE_W = $clog2(2 * MAX_BITS) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_TRAIL = 2'd2;

  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};
  localparam logic [BITS_W-1:0] MAX_N    = BITS_W'(MAX_BITS);

  logic [1:0]        state_r;
  logic [DIV_W-1:0]  cnt_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic              cpol_r;
  logic              cpha_r;
  logic [SPPR_W-1:0] sppr_r;
  logic [SPR_W-1:0]  spr_r;
  logic [BITS_W-1:0] nbits_r;

  logic              run_ok_s;
  logic              hold_s;
  logic [BITS_W-1:0] nbits_sel_s;
  logic [DIV_W-1:0]  half_s;
  logic              tick_s;
  logic [EDGE_W-1:0] edge_nxt_s;
  logic [EDGE_W-1:0] two_n_s;
  logic [EDGE_W-1:0] last_edge_s;
  logic              final_s;
  logic              lead_s;
  logic              sample_nxt_s;
  logic              shift_nxt_s;
  logic              last_nxt_s;

  // Baud divisor is reported straight from the live register fields.
  assign BaudRateDivisor_o =
    ({{(DIV_W-SPPR_W){1'b0}}, sppr_i} + DIV_ONE) << ({1'b0, spr_i} + {{SPR_W{1'b0}}, 1'b1});

  // Run qualification, frame-length clamp, half-period tick and strobe decode for the next edge.
  always_comb begin
    run_ok_s     = en_i & ~spiswai_i & ((spi_mode_i == 2'b00) | (spi_mode_i == 2'b01));
`ifdef SPI_SCLK_HOLD_EN
    hold_s       = hold_i;
`else
    hold_s       = 1'b0;
`endif
    if ((nbits_i == {BITS_W{1'b0}}) || (nbits_i > MAX_N)) begin
      nbits_sel_s = MAX_N;
    end else begin
      nbits_sel_s = nbits_i;
    end
    half_s       = {{(DIV_W-SPPR_W){1'b0}}, sppr_r} + DIV_ONE;
    half_s       = half_s << spr_r;
    tick_s       = (cnt_r == (half_s - DIV_ONE));
    edge_nxt_s   = edge_cnt_r + EDGE_ONE;
    two_n_s      = EDGE_W'({nbits_r, 1'b0});
    // The final sample lands on the last leading edge for CPHA=0, on the very last edge for CPHA=1.
    last_edge_s  = cpha_r ? two_n_s : (two_n_s - EDGE_ONE);
    final_s      = (edge_nxt_s == two_n_s);
    lead_s       = edge_nxt_s[0];
    sample_nxt_s = cpha_r ? ~lead_s : lead_s;
    // With CPHA=0 the trailing edge after the final bit has nothing left to shift.
    shift_nxt_s  = cpha_r ? lead_s : (~lead_s & ~final_s);
    last_nxt_s   = sample_nxt_s & (edge_nxt_s == last_edge_s);
  end

  // Frame sequencer: latches config at start, paces SCLK edges, emits registered strobes.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {DIV_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      sppr_r     <= {SPPR_W{1'b0}};
      spr_r      <= {SPR_W{1'b0}};
      nbits_r    <= {BITS_W{1'b0}};
      sclk_o     <= 1'b0;
      ss_n_o     <= 1'b1;
      busy_o     <= 1'b0;
      load_o     <= 1'b0;
      shift_o    <= 1'b0;
      sample_o   <= 1'b0;
      last_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      load_o   <= 1'b0;
      shift_o  <= 1'b0;
      sample_o <= 1'b0;
      last_o   <= 1'b0;
      done_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk_o     <= cpol_i;
          ss_n_o     <= 1'b1;
          busy_o     <= 1'b0;
          cnt_r      <= {DIV_W{1'b0}};
          edge_cnt_r <= {EDGE_W{1'b0}};
          if (start_i && run_ok_s) begin
            state_r <= ST_RUN;
            cpol_r  <= cpol_i;
            cpha_r  <= cphase_i;
            sppr_r  <= sppr_i;
            spr_r   <= spr_i;
            nbits_r <= nbits_sel_s;
            ss_n_o  <= 1'b0;
            busy_o  <= 1'b1;
            load_o  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_ok_s) begin
            state_r    <= ST_IDLE;
            sclk_o     <= cpol_i;
            ss_n_o     <= 1'b1;
            busy_o     <= 1'b0;
            cnt_r      <= {DIV_W{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
          end else if (hold_s) begin
            cnt_r <= cnt_r;
          end else if (tick_s) begin
            cnt_r      <= {DIV_W{1'b0}};
            sclk_o     <= ~sclk_o;
            edge_cnt_r <= edge_nxt_s;
            shift_o    <= shift_nxt_s;
            sample_o   <= sample_nxt_s;
            last_o     <= last_nxt_s;
            if (final_s) begin
              state_r <= ST_TRAIL;
            end
          end else begin
            cnt_r <= cnt_r + DIV_ONE;
          end
        end
        ST_TRAIL: begin
          if (!run_ok_s) begin
            state_r    <= ST_IDLE;
            sclk_o     <= cpol_i;
            ss_n_o     <= 1'b1;
            busy_o     <= 1'b0;
            cnt_r      <= {DIV_W{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
          end else if (hold_s) begin
            cnt_r <= cnt_r;
          end else if (tick_s) begin
            state_r    <= ST_IDLE;
            sclk_o     <= cpol_r;
            ss_n_o     <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            cnt_r      <= {DIV_W{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
          end else begin
            sclk_o <= cpol_r;
            cnt_r  <= cnt_r + DIV_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          sclk_o     <= cpol_i;
          ss_n_o     <= 1'b1;
          busy_o     <= 1'b0;
          cnt_r      <= {DIV_W{1'b0}};
          edge_cnt_r <= {EDGE_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb_spi_sclk_engine
//   Directed and randomised frames against a cycle-offset reference model:
//   every sampled cycle is mapped to an elapsed (non-held) cycle count e since
//   the start edge, from which SCLK level, edge number e/H and the expected
//   strobes follow by plain arithmetic.
module tb_spi_sclk_engine;

  logic        PCLK = 1'b0;
  logic        PRESET_n = 1'b1;
  logic        en_i, spiswai_i, cpol_i, cphase_i, start_i;
  logic [1:0]  spi_mode_i;
  logic [2:0]  sppr_i, spr_i;
  logic [5:0]  nbits_i;
`ifdef SPI_SCLK_HOLD_EN
  logic        hold_i = 1'b0;
`endif
  logic        sclk_o, ss_n_o, busy_o, load_o, shift_o, sample_o, last_o, done_o;
  logic [11:0] BaudRateDivisor_o;

  int vectors = 0;
  int fails   = 0;
  int obs_sample, obs_shift, obs_load, obs_last, obs_tog, obs_done_c;

  spi_sclk_engine dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .en_i(en_i), .spi_mode_i(spi_mode_i),
    .spiswai_i(spiswai_i), .cpol_i(cpol_i), .cphase_i(cphase_i), .sppr_i(sppr_i),
    .spr_i(spr_i), .nbits_i(nbits_i), .start_i(start_i),
`ifdef SPI_SCLK_HOLD_EN
    .hold_i(hold_i),
`endif
    .sclk_o(sclk_o), .ss_n_o(ss_n_o), .busy_o(busy_o), .load_o(load_o),
    .shift_o(shift_o), .sample_o(sample_o), .last_o(last_o), .done_o(done_o),
    .BaudRateDivisor_o(BaudRateDivisor_o)
  );

  always #5 PCLK = ~PCLK;

  // Output vector is {sclk, ss_n, busy, load, shift, sample, last, done}.
  task automatic chk(input string tag, input logic [7:0] exp_v);
    logic [7:0] obs;
    int dexp;
    obs = {sclk_o, ss_n_o, busy_o, load_o, shift_o, sample_o, last_o, done_o};
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp_v);
    end
    dexp = (int'(sppr_i) + 1) * (2 ** (int'(spr_i) + 1));
    vectors++;
    assert (BaudRateDivisor_o === 12'(dexp)) else begin
      fails++;
      $error("FAIL divisor t=%0t observed=%0d expected=%0d", $time, BaudRateDivisor_o, dexp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // hold_sel: 0 none, 1 random hold, 2 hold for edges c=7..9 (only with the hold build)
  task automatic run_frame(input logic cpol, input logic cpha, input logic [2:0] sppr,
                           input logic [2:0] spr, input logic [5:0] nbits,
                           input int abort_at, input bit noise, input int hold_sel);
    int h, n, e, c, q, limit;
    bit held_now, abort_now, edge_now, lead, samp, shf, lst, fin;
    logic prev_sclk;
    logic [7:0] exp_v;
    h = (int'(sppr) + 1) << int'(spr);
    n = ((nbits == 6'd0) || (int'(nbits) > 32)) ? 32 : int'(nbits);
    limit = 4 * (2 * n + 1) * h + 16;
    obs_sample = 0; obs_shift = 0; obs_load = 0; obs_last = 0; obs_tog = 0; obs_done_c = -1;
    en_i = 1'b1; spiswai_i = 1'b0; spi_mode_i = 2'($urandom_range(0, 1));
    cpol_i = cpol; cphase_i = cpha; sppr_i = sppr; spr_i = spr; nbits_i = nbits;
    start_i = 1'b1;
    @(posedge PCLK); #1;
    start_i = 1'b0;
    e = 0; c = 0;
    chk("start", {cpol, 1'b0, 1'b1, 1'b1, 4'b0000});
    obs_load += int'(load_o);
    prev_sclk = sclk_o;
    while (1) begin
      if (noise) begin
        start_i  = 1'($urandom_range(0, 1));
        cpol_i   = 1'($urandom_range(0, 1));
        cphase_i = 1'($urandom_range(0, 1));
        sppr_i   = 3'($urandom_range(0, 7));
        spr_i    = 3'($urandom_range(0, 7));
        nbits_i  = 6'($urandom_range(0, 63));
      end
      held_now = 1'b0;
`ifdef SPI_SCLK_HOLD_EN
      if (hold_sel == 1) hold_i = ($urandom_range(0, 3) == 0);
      else if (hold_sel == 2) hold_i = ((c + 1) >= 7) && ((c + 1) <= 9);
      else hold_i = 1'b0;
      held_now = hold_i;
`endif
      abort_now = ((c + 1) == abort_at);
      if (abort_now) begin
        spi_mode_i = 2'b01;
        spiswai_i  = 1'b1;
      end
      @(posedge PCLK); #1;
      c++;
      if (abort_now) begin
        chk("abort", {cpol_i, 1'b1, 6'b000000});
        spiswai_i = 1'b0;
        break;
      end
      if (!held_now) e++;
      q        = e / h;
      fin      = (e == (2 * n + 1) * h);
      edge_now = !held_now && ((e % h) == 0) && (q >= 1) && (q <= 2 * n);
      lead     = ((q % 2) == 1);
      samp     = edge_now && (cpha ? !lead : lead);
      shf      = edge_now && (cpha ? lead : (!lead && (q != 2 * n)));
      lst      = samp && (q == (cpha ? 2 * n : 2 * n - 1));
      if (fin) exp_v = {cpol, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1};
      else     exp_v = {cpol ^ lead, 1'b0, 1'b1, 1'b0, shf, samp, lst, 1'b0};
      chk("frame", exp_v);
      obs_sample += int'(sample_o);
      obs_shift  += int'(shift_o);
      obs_load   += int'(load_o);
      obs_last   += int'(last_o);
      if (sclk_o !== prev_sclk) obs_tog++;
      prev_sclk = sclk_o;
      if (fin) begin
        obs_done_c = c;
        break;
      end
      if (c >= limit) begin
        vectors++;
        fails++;
        $error("FAIL timeout observed=%0d cycles expected<%0d", c, limit);
        break;
      end
    end
    start_i = 1'b0; en_i = 1'b1; spiswai_i = 1'b0;
`ifdef SPI_SCLK_HOLD_EN
    hold_i = 1'b0;
`endif
    @(posedge PCLK); #1;
    chk("idle_after", {cpol_i, 1'b1, 6'b000000});
  endtask

  initial begin
    en_i = 1'b0; spiswai_i = 1'b0; spi_mode_i = 2'b00; cpol_i = 1'b0; cphase_i = 1'b0;
    sppr_i = 3'd0; spr_i = 3'd0; nbits_i = 6'd0; start_i = 1'b0;
    #1 PRESET_n = 1'b0;
    #2 chk("reset", 8'b0100_0000);
    #20 PRESET_n = 1'b1;
    @(posedge PCLK); #1;
    chk("idle", 8'b0100_0000);

    // H=1, 4 bits: 8 toggles, done at t0+9
    run_frame(1'b0, 1'b0, 3'd0, 3'd0, 6'd4, -1, 1'b0, 0);
    chk_int("h1_done", obs_done_c, 9);
    chk_int("h1_toggles", obs_tog, 8);
    sppr_i = 3'd0; spr_i = 3'd0; #1;
    chk_int("div_min", int'(BaudRateDivisor_o), 2);

    // mode 0, H=2, 8 bits
    run_frame(1'b0, 1'b0, 3'd1, 3'd0, 6'd8, -1, 1'b0, 0);
    chk_int("m0_samples", obs_sample, 8);
    chk_int("m0_shifts", obs_shift, 7);
    chk_int("m0_loads", obs_load, 1);
    chk_int("m0_lasts", obs_last, 1);
    chk_int("m0_done", obs_done_c, 34);

    // mode 3, H=2, 8 bits
    run_frame(1'b1, 1'b1, 3'd1, 3'd0, 6'd8, -1, 1'b0, 0);
    chk_int("m3_shifts", obs_shift, 8);
    chk_int("m3_samples", obs_sample, 8);
    chk_int("m3_done", obs_done_c, 34);

    // nbits=0 and nbits=33 both clamp to 32 bits
    run_frame(1'b0, 1'b0, 3'd0, 3'd0, 6'd0, -1, 1'b0, 0);
    chk_int("n0_samples", obs_sample, 32);
    chk_int("n0_toggles", obs_tog, 64);
    chk_int("n0_done", obs_done_c, 65);
    run_frame(1'b1, 1'b1, 3'd0, 3'd0, 6'd33, -1, 1'b0, 0);
    chk_int("n33_done", obs_done_c, 65);

    // abort after edge 5 (H=2 -> edge 5 at c=10), then a clean frame
    run_frame(1'b0, 1'b0, 3'd1, 3'd0, 6'd8, 11, 1'b0, 0);
    chk_int("abort_no_done", obs_done_c, -1);
    chk_int("abort_no_last", obs_last, 0);
    run_frame(1'b0, 1'b0, 3'd1, 3'd0, 6'd8, -1, 1'b0, 0);
    chk_int("post_abort_done", obs_done_c, 34);

`ifdef SPI_SCLK_HOLD_EN
    run_frame(1'b0, 1'b0, 3'd1, 3'd0, 6'd8, -1, 1'b0, 2);
    chk_int("hold_done", obs_done_c, 37);
    chk_int("hold_samples", obs_sample, 8);
    chk_int("hold_shifts", obs_shift, 7);
`endif

    // start together with abort: no frame
    cpol_i = 1'b1; en_i = 1'b0; start_i = 1'b1;
    @(posedge PCLK); #1;
    chk("start_abort", {cpol_i, 1'b1, 6'b000000});
    start_i = 1'b0; en_i = 1'b1;
    @(posedge PCLK); #1;
    chk("start_abort_idle", {cpol_i, 1'b1, 6'b000000});

    // async reset mid-frame
    cpol_i = 1'b1; cphase_i = 1'b0; sppr_i = 3'd0; spr_i = 3'd0; nbits_i = 6'd8;
    spi_mode_i = 2'b00; start_i = 1'b1;
    @(posedge PCLK); #1;
    start_i = 1'b0;
    repeat (3) @(posedge PCLK);
    #2 PRESET_n = 1'b0;
    #1 chk("reset_mid", 8'b0100_0000);
    @(posedge PCLK); #2 PRESET_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      chk("post_reset_idle", {cpol_i, 1'b1, 6'b000000});
    end

    // randomised frames with input noise, random aborts and (if built) random hold
    for (int i = 0; i < 20; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 2)),
                6'($urandom_range(0, 63)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1,
                1'b1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
